// File: rtl/hilo_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_pipe_pkg
// Brief    : Shared HI/LO write-enable encodings and slot sizing helpers.
// Revision : 1.0
// ============================================================================
package hilo_pipe_pkg;

    // Write-enable encodings, bit 1 = HI, bit 0 = LO
    localparam logic [1:0] HILO_WE_NONE = 2'b00;
    localparam logic [1:0] HILO_WE_LO   = 2'b01;
    localparam logic [1:0] HILO_WE_HI   = 2'b10;
    localparam logic [1:0] HILO_WE_BOTH = 2'b11;

    localparam int HILO_DW_DEFAULT = 32;

    // A slot packs {we[1:0], hi, lo}
    function automatic int slot_width(input int dw);
        return 2 + 2 * dw;
    endfunction

    localparam int HILO_SLOT_W = slot_width(HILO_DW_DEFAULT);

endpackage : hilo_pipe_pkg
`default_nettype wire

// File: rtl/hilo_slot.sv
`default_nettype none
// ============================================================================
// Module   : hilo_slot
// Brief    : One HI/LO pipeline slot register with load, hold and bubble.
// Revision : 1.0
// ============================================================================
module hilo_slot
    import hilo_pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          bubble,
    input  logic [1:0]    d_we,
    input  logic [DW-1:0] d_hi,
    input  logic [DW-1:0] d_lo,
    output logic [1:0]    q_we,
    output logic [DW-1:0] q_hi,
    output logic [DW-1:0] q_lo
);

    localparam int SW = slot_width(DW);

    logic [SW-1:0] r_slot;

    // A bubble only clears the enables; stale data is harmless once we = 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot <= '0;
        end else if (bubble) begin
            r_slot[SW-1 -: 2] <= HILO_WE_NONE;
        end else if (load) begin
            r_slot <= {d_we, d_hi, d_lo};
        end
    end

    assign q_we = r_slot[SW-1 -: 2];
    assign q_hi = r_slot[2*DW-1 -: DW];
    assign q_lo = r_slot[DW-1:0];

endmodule : hilo_slot
`default_nettype wire

// File: rtl/hilo_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hilo_pipe
// Brief    : HI/LO MEM/WB pipeline with architectural commit and operand
//            return. Define HILO_FWD_EN to forward from M/W; otherwise a
//            read-after-write hazard stalls the front end until writes drain.
// Revision : 1.0
// ============================================================================
module hilo_pipe
    import hilo_pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush_m,
    input  logic [1:0]      ex_we,
    input  logic [1:0]      ex_rd,
    input  logic [2*DW-1:0] ex_y,
    input  logic            ex_div_stall,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o,
    output logic [DW-1:0]   hi_arch,
    output logic [DW-1:0]   lo_arch,
    output logic            hazard_stall
);

    logic [1:0]    m_we;
    logic [DW-1:0] m_hi;
    logic [DW-1:0] m_lo;
    logic [1:0]    w_we;
    logic [DW-1:0] w_hi;
    logic [DW-1:0] w_lo;

    logic          w_advance;
    logic          w_m_bubble;
    logic          w_hazard;
    logic [DW-1:0] r_hi_arch;
    logic [DW-1:0] r_lo_arch;

    // A flush forces the pipe forward even when the global stall is high.
    assign w_advance  = flush_m | ~stall;
    assign w_m_bubble = flush_m | (~stall & (ex_div_stall | w_hazard));

    hilo_slot #(
        .DW (DW)
    ) u_slot_m (
        .clk    (clk),
        .rst    (rst),
        .load   (~stall),
        .bubble (w_m_bubble),
        .d_we   (ex_we),
        .d_hi   (ex_y[2*DW-1:DW]),
        .d_lo   (ex_y[DW-1:0]),
        .q_we   (m_we),
        .q_hi   (m_hi),
        .q_lo   (m_lo)
    );

    // M is always the flushed slot, so W receives a bubble on a flush.
    hilo_slot #(
        .DW (DW)
    ) u_slot_w (
        .clk    (clk),
        .rst    (rst),
        .load   (~stall),
        .bubble (flush_m),
        .d_we   (m_we),
        .d_hi   (m_hi),
        .d_lo   (m_lo),
        .q_we   (w_we),
        .q_hi   (w_hi),
        .q_lo   (w_lo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi_arch <= '0;
            r_lo_arch <= '0;
        end else if (w_advance) begin
            if (w_we[1]) begin
                r_hi_arch <= w_hi;
            end
            if (w_we[0]) begin
                r_lo_arch <= w_lo;
            end
        end
    end

    assign hi_arch = r_hi_arch;
    assign lo_arch = r_lo_arch;

`ifdef HILO_FWD_EN
    logic unused_rd;
    assign unused_rd = ^ex_rd;
    assign w_hazard  = 1'b0;

    // Youngest writer wins, resolved independently per half.
    always_comb begin
        hi_o = r_hi_arch;
        if (m_we[1]) begin
            hi_o = m_hi;
        end else if (w_we[1]) begin
            hi_o = w_hi;
        end
        lo_o = r_lo_arch;
        if (m_we[0]) begin
            lo_o = m_lo;
        end else if (w_we[0]) begin
            lo_o = w_lo;
        end
    end
`else
    assign w_hazard = (ex_rd[1] & (m_we[1] | w_we[1]))
                    | (ex_rd[0] & (m_we[0] | w_we[0]));
    assign hi_o     = r_hi_arch;
    assign lo_o     = r_lo_arch;
`endif

    assign hazard_stall = w_hazard;

endmodule : hilo_pipe
`default_nettype wire

// File: tb/tb_hilo_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_pipe
// Brief    : Directed vector bench for hilo_pipe (either HILO_FWD_EN build).
// Revision : 1.0
// ============================================================================
module tb_hilo_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush_m = 1'b0;
    logic [1:0]  ex_we = 2'b00;
    logic [1:0]  ex_rd = 2'b00;
    logic [63:0] ex_y = '0;
    logic        ex_div_stall = 1'b0;
    logic [31:0] hi_o, lo_o, hi_arch, lo_arch;
    logic        hazard_stall;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        st;
        logic        fl;
        logic [1:0]  we;
        logic        dv;
        logic [63:0] y;
        logic [31:0] ahi;
        logic [31:0] alo;
        logic [31:0] fhi;
        logic [31:0] flo;
    } vec_t;

    vec_t tbl[$];

    hilo_pipe #(.DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush_m      (flush_m),
        .ex_we        (ex_we),
        .ex_rd        (ex_rd),
        .ex_y         (ex_y),
        .ex_div_stall (ex_div_stall),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .hi_arch      (hi_arch),
        .lo_arch      (lo_arch),
        .hazard_stall (hazard_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic st, input logic fl, input logic [1:0] we,
                                input logic dv, input logic [63:0] y,
                                input logic [31:0] ahi, input logic [31:0] alo,
                                input logic [31:0] fhi, input logic [31:0] flo);
        vec_t v;
        v.st = st; v.fl = fl; v.we = we; v.dv = dv; v.y = y;
        v.ahi = ahi; v.alo = alo; v.fhi = fhi; v.flo = flo;
        tbl.push_back(v);
    endfunction

    // fhi/flo are the forwarded operands; without forwarding the operands track arch.
    task automatic check_row(input string tag, input logic [31:0] ahi, input logic [31:0] alo,
                             input logic [31:0] fhi, input logic [31:0] flo);
        chk({tag, " hi_arch"}, hi_arch, ahi);
        chk({tag, " lo_arch"}, lo_arch, alo);
`ifdef HILO_FWD_EN
        chk({tag, " hi_o"}, hi_o, fhi);
        chk({tag, " lo_o"}, lo_o, flo);
`else
        chk({tag, " hi_o"}, hi_o, ahi);
        chk({tag, " lo_o"}, lo_o, alo);
`endif
        chk({tag, " hazard"}, {31'd0, hazard_stall}, 32'd0);
    endtask

    initial begin
        // Sequence from a clean reset; ex_rd stays 0 throughout the table.
        add(0,0,2'b11,0,{32'h1,32'h2},                 32'h0,32'h0, 32'h1,32'h2);
        add(0,0,2'b00,0,64'h0,                         32'h0,32'h0, 32'h1,32'h2);
        add(0,0,2'b00,0,64'h0,                         32'h1,32'h2, 32'h1,32'h2);
        add(0,0,2'b10,0,{32'hDEADBEEF,32'h5555},       32'h1,32'h2, 32'hDEADBEEF,32'h2);
        add(0,0,2'b00,0,64'h0,                         32'h1,32'h2, 32'hDEADBEEF,32'h2);
        add(0,0,2'b00,0,64'h0,                         32'hDEADBEEF,32'h2, 32'hDEADBEEF,32'h2);
        for (int i = 0; i < 5; i++)
            add(0,0,2'b11,1,{32'hAAAA,32'hBBBB},       32'hDEADBEEF,32'h2, 32'hDEADBEEF,32'h2);
        add(0,0,2'b11,0,{32'h3,32'h7},                 32'hDEADBEEF,32'h2, 32'h3,32'h7);
        add(0,0,2'b00,0,64'h0,                         32'hDEADBEEF,32'h2, 32'h3,32'h7);
        add(0,0,2'b00,0,64'h0,                         32'h3,32'h7, 32'h3,32'h7);
        add(0,0,2'b01,0,{32'hFFFFFFFF,32'h42},         32'h3,32'h7, 32'h3,32'h42);
        add(0,0,2'b00,0,64'h0,                         32'h3,32'h7, 32'h3,32'h42);
        add(0,0,2'b00,0,64'h0,                         32'h3,32'h42, 32'h3,32'h42);
        add(0,0,2'b10,0,{32'h11,32'h0},                32'h3,32'h42, 32'h11,32'h42);
        add(0,0,2'b10,0,{32'h22,32'h0},                32'h3,32'h42, 32'h22,32'h42);
        add(0,0,2'b00,0,64'h0,                         32'h11,32'h42, 32'h22,32'h42);
        add(0,0,2'b00,0,64'h0,                         32'h22,32'h42, 32'h22,32'h42);
        // Flush with M=5, W=9, stall also high: W commits, M and incoming EX die
        add(0,0,2'b10,0,{32'h9,32'h0},                 32'h22,32'h42, 32'h9,32'h42);
        add(0,0,2'b10,0,{32'h5,32'h0},                 32'h22,32'h42, 32'h5,32'h42);
        add(1,1,2'b11,0,{32'h77,32'h77},               32'h9,32'h42, 32'h9,32'h42);
        add(0,0,2'b00,0,64'h0,                         32'h9,32'h42, 32'h9,32'h42);
        add(0,0,2'b00,0,64'h0,                         32'h9,32'h42, 32'h9,32'h42);
        // Stall with both slots occupied
        add(0,0,2'b11,0,{32'hA1,32'hB1},               32'h9,32'h42, 32'hA1,32'hB1);
        add(0,0,2'b11,0,{32'hA2,32'hB2},               32'h9,32'h42, 32'hA2,32'hB2);
        for (int i = 0; i < 3; i++)
            add(1,0,2'b11,0,{32'hFF,32'hFF},           32'h9,32'h42, 32'hA2,32'hB2);
        add(0,0,2'b00,0,64'h0,                         32'hA1,32'hB1, 32'hA2,32'hB2);
        add(0,0,2'b00,0,64'h0,                         32'hA2,32'hB2, 32'hA2,32'hB2);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_row("reset", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            stall = tbl[i].st; flush_m = tbl[i].fl; ex_we = tbl[i].we;
            ex_div_stall = tbl[i].dv; ex_y = tbl[i].y;
            @(posedge clk);
            #1;
            check_row($sformatf("vec%0d", i), tbl[i].ahi, tbl[i].alo, tbl[i].fhi, tbl[i].flo);
        end

        // LO write immediately followed by a LO reader
        @(negedge clk);
        stall = 0; flush_m = 0; ex_div_stall = 0;
        ex_we = 2'b01; ex_y = {32'h0, 32'h1234}; ex_rd = 2'b00;
        @(posedge clk);
        #1;
        ex_we = 2'b00; ex_rd = 2'b01; ex_y = '0;
        #1;
`ifdef HILO_FWD_EN
        chk("raw1 hazard", {31'd0, hazard_stall}, 32'd0);
        chk("raw1 lo_o", lo_o, 32'h1234);
`else
        chk("raw1 hazard", {31'd0, hazard_stall}, 32'd1);
        chk("raw1 lo_o", lo_o, 32'hB2);
`endif
        @(posedge clk);
        #1;
`ifdef HILO_FWD_EN
        chk("raw2 hazard", {31'd0, hazard_stall}, 32'd0);
        chk("raw2 lo_o", lo_o, 32'h1234);
`else
        chk("raw2 hazard", {31'd0, hazard_stall}, 32'd1);
        chk("raw2 lo_o", lo_o, 32'hB2);
`endif
        @(posedge clk);
        #1;
        chk("raw3 hazard", {31'd0, hazard_stall}, 32'd0);
        chk("raw3 lo_o", lo_o, 32'h1234);
        chk("raw3 lo_arch", lo_arch, 32'h1234);
        ex_rd = 2'b00;

        // Asynchronous reset with a live entry in M discards it
        @(negedge clk);
        ex_we = 2'b11; ex_y = {32'hC, 32'hD};
        @(posedge clk);
        #1;
        ex_we = 2'b00; ex_y = '0;
        #1;
        rst = 1'b0;
        #1;
        check_row("areset", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_row($sformatf("post_rst%0d", i), 32'h0, 32'h0, 32'h0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_hilo_pipe
`default_nettype wire
